// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the parametrised IEEE-754 square-root unit.
// Covers the FSM states, operand classes, rounding-mode codes and canonical NaN.
package fp_sqrt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_NORM     = 3'd2,
        ST_ITER     = 3'd3,
        ST_PACK     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } cls_t;

    localparam logic RM_RTZ = 1'b0;
    localparam logic RM_RNE = 1'b1;

    localparam int MAX_W = 64;

    // Quiet NaN with the sign set: {1, all-ones exponent, 1, zeros}, right-aligned.
    function automatic logic [MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] v;
        v = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            if (i == man_w - 1 || (i >= man_w && i <= man_w + exp_w)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_sqrt_step.sv
// One iteration of the restoring square root: resolves BPC root bits from
// 2*BPC new radicand bits, updating the partial remainder and partial root.
module fp_sqrt_step #(
    parameter int RW  = 14,
    parameter int QW  = 12,
    parameter int BPC = 1
) (
    input  logic [RW-1:0]    rem,
    input  logic [QW-1:0]    root,
    input  logic [2*BPC-1:0] bits,
    output logic [RW-1:0]    rem_next,
    output logic [QW-1:0]    root_next
);

    localparam int XW = RW + 2;

    logic [XW-1:0] r_s;
    logic [XW-1:0] t_s;
    logic [QW-1:0] q_s;

    // Radix-2 restoring steps, most significant bit pair first.
    always_comb begin
        r_s = XW'(rem);
        q_s = root;
        t_s = {XW{1'b0}};
        for (int i = BPC - 1; i >= 0; i--) begin
            r_s = {r_s[XW-3:0], bits[2*i+1], bits[2*i]};
            t_s = XW'({q_s, 2'b01});
            if (r_s >= t_s) begin
                r_s = r_s - t_s;
                q_s = {q_s[QW-2:0], 1'b1};
            end else begin
                q_s = {q_s[QW-2:0], 1'b0};
            end
        end
        rem_next  = r_s[RW-1:0];
        root_next = q_s;
    end

endmodule

// File: rtl/fp_sqrt_param.sv
// Parametrised IEEE-754 square root on a shared bidirectional bus with an
// ENABLE/RESULT handshake; selectable RTZ/RNE rounding and an inexact flag.
module fp_sqrt_param
    import fp_sqrt_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BPC   = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   ENABLE,
    input  logic                   RM,
    inout  wire  [EXP_W+MAN_W:0]   IO_DATA,
    output logic                   RESULT,
    output logic                   IS_NAN,
    output logic                   IS_PINF,
    output logic                   IS_NINF,
    output logic                   IS_INEXACT
);

    localparam int W    = EXP_W + MAN_W + 1;
    localparam int QW   = MAN_W + 2;
    localparam int RW   = MAN_W + 4;
    localparam int N    = (QW + BPC - 1) / BPC;
    localparam int DW   = 2 * N * BPC;
    localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
    localparam int LW   = $clog2(MAN_W + 1);
    localparam int EW   = EXP_W + LW + 2;
    localparam int CW   = $clog2(N + 1);
    localparam logic [MAX_W-1:0] NAN_WIDE = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]     NAN_VAL  = NAN_WIDE[W-1:0];

    state_t          state_r;
    logic            armed_r;
    logic [W-1:0]    op_r;
    logic            rm_r;
    logic            special_r;
    logic [W-1:0]    spec_val_r;
    logic            spec_nan_r;
    logic            spec_pinf_r;
    logic [EW-1:0]   exp_r;
    logic [DW-1:0]   rad_r;
    logic [RW-1:0]   rem_r;
    logic [QW-1:0]   root_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    out_r;
    logic            result_r;
    logic            nan_r;
    logic            pinf_r;
    logic            inx_r;

    logic                 sign_s;
    logic [EXP_W-1:0]     e_fld_s;
    logic [MAN_W-1:0]     m_fld_s;
    cls_t                 cls_s;
    logic [LW-1:0]        lz_s;
    logic [MAN_W:0]       sig_s;
    logic signed [EW-1:0] e_unb_s;
    logic signed [EW-1:0] e_even_s;
    logic signed [EW-1:0] res_exp_s;
    logic                 odd_s;
    logic [QW-1:0]        aligned_s;
    logic [DW-1:0]        rad_load_s;
    logic [RW-1:0]        rem_nx_s;
    logic [QW-1:0]        root_nx_s;
    logic                 rem_nz_s;
    logic                 inc_s;
    logic [MAN_W:0]       sum_s;
    logic [EW-1:0]        exp_pack_s;
    logic [W-1:0]         word_s;
    logic                 sticky_s;
    logic                 unused_s;

    assign sign_s  = op_r[W-1];
    assign e_fld_s = op_r[W-2:MAN_W];
    assign m_fld_s = op_r[MAN_W-1:0];

    // Operand decode, subnormal normalisation and exponent halving.
    always_comb begin
        if (e_fld_s == {EXP_W{1'b0}}) begin
            cls_s = (m_fld_s == {MAN_W{1'b0}}) ? CLS_ZERO : CLS_SUB;
        end else if (e_fld_s == {EXP_W{1'b1}}) begin
            cls_s = (m_fld_s == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
        end else begin
            cls_s = CLS_NORM;
        end

        lz_s = LW'(MAN_W);
        for (int i = 0; i < MAN_W; i++) begin
            if (m_fld_s[i]) begin
                lz_s = LW'(MAN_W - 1 - i);
            end else begin
                lz_s = lz_s;
            end
        end

        if (cls_s == CLS_SUB) begin
            sig_s   = {m_fld_s, 1'b0} << lz_s;
            e_unb_s = -$signed(EW'(BIAS)) - $signed(EW'(lz_s));
        end else begin
            sig_s   = {1'b1, m_fld_s};
            e_unb_s = $signed(EW'(e_fld_s)) - $signed(EW'(BIAS));
        end

        // An odd exponent moves one factor of two into the significand.
        odd_s      = e_unb_s[0];
        aligned_s  = odd_s ? {sig_s, 1'b0} : {1'b0, sig_s};
        e_even_s   = e_unb_s - $signed(EW'(odd_s));
        res_exp_s  = (e_even_s >>> 1) + $signed(EW'(BIAS));
        rad_load_s = DW'({aligned_s, {QW{1'b0}}});
    end

    fp_sqrt_step #(
        .RW  (RW),
        .QW  (QW),
        .BPC (BPC)
    ) u_step (
        .rem       (rem_r),
        .root      (root_r),
        .bits      (rad_r[DW-1 -: 2*BPC]),
        .rem_next  (rem_nx_s),
        .root_next (root_nx_s)
    );

    // Rounding and packing of the computed root.
    always_comb begin
        rem_nz_s   = (rem_r != {RW{1'b0}});
        inc_s      = (rm_r == RM_RNE) && root_r[0] && (rem_nz_s || root_r[1]);
        sum_s      = {1'b0, root_r[MAN_W:1]} + {{MAN_W{1'b0}}, inc_s};
        exp_pack_s = exp_r + {{(EW-1){1'b0}}, sum_s[MAN_W]};
        word_s     = {1'b0, exp_pack_s[EXP_W-1:0], sum_s[MAN_W-1:0]};
        sticky_s   = rem_nz_s || root_r[0];
    end

    assign unused_s = ^exp_pack_s[EW-1:EXP_W];

    // Control FSM and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            armed_r     <= 1'b0;
            op_r        <= {W{1'b0}};
            rm_r        <= 1'b0;
            special_r   <= 1'b0;
            spec_val_r  <= {W{1'b0}};
            spec_nan_r  <= 1'b0;
            spec_pinf_r <= 1'b0;
            exp_r       <= {EW{1'b0}};
            rad_r       <= {DW{1'b0}};
            rem_r       <= {RW{1'b0}};
            root_r      <= {QW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            out_r       <= {W{1'b0}};
            result_r    <= 1'b0;
            nan_r       <= 1'b0;
            pinf_r      <= 1'b0;
            inx_r       <= 1'b0;
        end else if (!ENABLE) begin
            armed_r  <= 1'b1;
            state_r  <= ST_IDLE;
            result_r <= 1'b0;
            nan_r    <= 1'b0;
            pinf_r   <= 1'b0;
            inx_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (armed_r) begin
                        op_r    <= IO_DATA;
                        rm_r    <= RM;
                        armed_r <= 1'b0;
                        state_r <= ST_CLASSIFY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLASSIFY: begin
                    special_r   <= 1'b1;
                    spec_nan_r  <= 1'b0;
                    spec_pinf_r <= 1'b0;
                    spec_val_r  <= op_r;
                    state_r     <= ST_PACK;
                    if (cls_s == CLS_NAN || (sign_s && cls_s != CLS_ZERO)) begin
                        spec_val_r <= NAN_VAL;
                        spec_nan_r <= 1'b1;
                    end else if (cls_s == CLS_INF) begin
                        spec_pinf_r <= 1'b1;
                    end else if (cls_s == CLS_ZERO) begin
                        spec_nan_r <= 1'b0;
                    end else begin
                        special_r <= 1'b0;
                        state_r   <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    exp_r   <= res_exp_s;
                    rad_r   <= rad_load_s;
                    rem_r   <= {RW{1'b0}};
                    root_r  <= {QW{1'b0}};
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_ITER;
                end
                ST_ITER: begin
                    rem_r  <= rem_nx_s;
                    root_r <= root_nx_s;
                    rad_r  <= rad_r << (2 * BPC);
                    if (cnt_r == CW'(N - 1)) begin
                        state_r <= ST_PACK;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_PACK: begin
                    if (special_r) begin
                        out_r  <= spec_val_r;
                        nan_r  <= spec_nan_r;
                        pinf_r <= spec_pinf_r;
                        inx_r  <= 1'b0;
                    end else begin
                        out_r  <= word_s;
                        nan_r  <= 1'b0;
                        pinf_r <= 1'b0;
                        inx_r  <= sticky_s;
                    end
                    result_r <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus released combinationally so it floats in the same cycle ENABLE falls.
    assign IO_DATA    = (state_r == ST_DONE && ENABLE) ? out_r : {W{1'bz}};
    assign RESULT     = result_r;
    assign IS_NAN     = nan_r;
    assign IS_PINF    = pinf_r;
    assign IS_NINF    = 1'b0;
    assign IS_INEXACT = inx_r;

endmodule

// File: tb/tb_fp_sqrt_param.sv
// Directed scoreboard bench for fp_sqrt_param: FP16/BPC1, BF16/BPC2 and FP32/BPC4
// instances sharing clock and reset, checked with immediate assertions.
module tb_fp_sqrt_param;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  en    = 3'b000;
    logic [2:0]  rm    = 3'b000;
    logic [2:0]  drv   = 3'b000;
    logic [31:0] hdata = 32'h0;
    wire  [15:0] io_h;
    wire  [15:0] io_b;
    wire  [31:0] io_f;
    wire  [2:0]  res, nan, pinf, ninf, inx;
    int          sel   = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] val;
        logic        nan;
        logic        pinf;
        logic        inx;
        int          lat;
        string       tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign io_h = drv[0] ? hdata[15:0] : 16'hzzzz;
    assign io_b = drv[1] ? hdata[15:0] : 16'hzzzz;
    assign io_f = drv[2] ? hdata       : 32'hzzzzzzzz;

    fp_sqrt_param #(.EXP_W(5), .MAN_W(10), .BPC(1)) u_h (
        .CLK(clk), .RST_N(rst_n), .ENABLE(en[0]), .RM(rm[0]), .IO_DATA(io_h),
        .RESULT(res[0]), .IS_NAN(nan[0]), .IS_PINF(pinf[0]), .IS_NINF(ninf[0]), .IS_INEXACT(inx[0]));
    fp_sqrt_param #(.EXP_W(8), .MAN_W(7), .BPC(2)) u_b (
        .CLK(clk), .RST_N(rst_n), .ENABLE(en[1]), .RM(rm[1]), .IO_DATA(io_b),
        .RESULT(res[1]), .IS_NAN(nan[1]), .IS_PINF(pinf[1]), .IS_NINF(ninf[1]), .IS_INEXACT(inx[1]));
    fp_sqrt_param #(.EXP_W(8), .MAN_W(23), .BPC(4)) u_f (
        .CLK(clk), .RST_N(rst_n), .ENABLE(en[2]), .RM(rm[2]), .IO_DATA(io_f),
        .RESULT(res[2]), .IS_NAN(nan[2]), .IS_PINF(pinf[2]), .IS_NINF(ninf[2]), .IS_INEXACT(inx[2]));

    logic [31:0] io_sel;
    logic        bus_z;

    always_comb begin
        case (sel)
            1:       begin io_sel = {16'h0, io_b}; bus_z = (io_b === 16'hzzzz); end
            2:       begin io_sel = io_f;          bus_z = (io_f === 32'hzzzzzzzz); end
            default: begin io_sel = {16'h0, io_h}; bus_z = (io_h === 16'hzzzz); end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int s, input logic [31:0] op, input logic r);
        @(negedge clk); en[s] = 1'b0;
        @(negedge clk); drv[s] = 1'b1; hdata = op; rm[s] = r; en[s] = 1'b1;
        @(negedge clk); drv[s] = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (res[sel] !== 1'b1 && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    task automatic drop(input int s, input string tag);
        @(negedge clk); en[s] = 1'b0; #1;
        check({tag, "/busz"}, {31'h0, bus_z}, 32'd1);
        @(negedge clk);
        check({tag, "/cleared"}, {27'h0, res[s], nan[s], pinf[s], ninf[s], inx[s]}, 32'h0);
    endtask

    task automatic run(input int s, input logic [31:0] op, input logic r, input logic [31:0] ev,
                       input logic n_e, input logic p_e, input logic x_e, input int lat_e,
                       input string tag);
        exp_t e;
        int   lat;
        sel = s;
        sb.push_back('{val: ev, nan: n_e, pinf: p_e, inx: x_e, lat: lat_e, tag: tag});
        capture(s, op, r);
        wait_result(lat);
        e = sb.pop_front();
        check({e.tag, "/result"}, {31'h0, res[s]}, 32'd1);
        check({e.tag, "/latency"}, 32'(lat), 32'(e.lat));
        check({e.tag, "/data"}, io_sel, e.val);
        check({e.tag, "/flags"}, {28'h0, nan[s], pinf[s], ninf[s], inx[s]},
              {28'h0, e.nan, e.pinf, 1'b0, e.inx});
        // ENABLE held high after DONE must neither restart nor disturb the result.
        repeat (3) @(negedge clk);
        check({e.tag, "/hold"}, {res[s], io_sel[30:0]}, {1'b1, e.val[30:0]});
        drop(s, e.tag);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("reset/result", {29'h0, res}, 32'h0);
        check("reset/flags", {20'h0, nan, pinf, ninf, inx}, 32'h0);
        check("reset/busz", {31'h0, bus_z}, 32'd1);
        rst_n = 1'b1;

        run(0, 32'h4400, 1'b0, 32'h4000, 1'b0, 1'b0, 1'b0, 15, "h4400_rtz");
        run(0, 32'h3800, 1'b0, 32'h39A8, 1'b0, 1'b0, 1'b1, 15, "h3800_rtz");
        run(0, 32'h0001, 1'b0, 32'h0C00, 1'b0, 1'b0, 1'b0, 15, "h0001_rtz");
        run(0, 32'h7BFF, 1'b0, 32'h5BFF, 1'b0, 1'b0, 1'b1, 15, "h7bff_rtz");
        run(0, 32'h4500, 1'b0, 32'h4078, 1'b0, 1'b0, 1'b1, 15, "h4500_rtz");
        run(0, 32'h4200, 1'b1, 32'h3EEE, 1'b0, 1'b0, 1'b1, 15, "h4200_rne");
        run(0, 32'h4200, 1'b0, 32'h3EED, 1'b0, 1'b0, 1'b1, 15, "h4200_rtz");
        run(0, 32'h4400, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 15, "h4400_rne");

        run(0, 32'h7C00, 1'b0, 32'h7C00, 1'b0, 1'b1, 1'b0, 2, "pinf");
        run(0, 32'hFC00, 1'b0, 32'hFE00, 1'b1, 1'b0, 1'b0, 2, "ninf_nan");
        run(0, 32'hBC00, 1'b1, 32'hFE00, 1'b1, 1'b0, 1'b0, 2, "neg_nan");
        run(0, 32'h7E00, 1'b0, 32'hFE00, 1'b1, 1'b0, 1'b0, 2, "qnan");
        run(0, 32'h8001, 1'b0, 32'hFE00, 1'b1, 1'b0, 1'b0, 2, "negsub_nan");
        run(0, 32'h8000, 1'b0, 32'h8000, 1'b0, 1'b0, 1'b0, 2, "nzero");
        run(0, 32'h0000, 1'b1, 32'h0000, 1'b0, 1'b0, 1'b0, 2, "pzero");

        run(1, 32'h4080, 1'b0, 32'h4000, 1'b0, 1'b0, 1'b0, 8, "bf16_4");
        run(2, 32'h40800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 10, "fp32_4");
        run(2, 32'h40000000, 1'b0, 32'h3FB504F3, 1'b0, 1'b0, 1'b1, 10, "fp32_2_rtz");
        run(2, 32'h40000000, 1'b1, 32'h3FB504F3, 1'b0, 1'b0, 1'b1, 10, "fp32_2_rne");

        // Abort mid-ITER, then a fresh request must run the full latency.
        sel = 0;
        capture(0, 32'h4500, 1'b0);
        repeat (6) @(negedge clk);
        en[0] = 1'b0; #1;
        check("abort/busz", {31'h0, bus_z}, 32'd1);
        @(negedge clk);
        check("abort/idle", {31'h0, res[0]}, 32'h0);
        run(0, 32'h3800, 1'b1, 32'h39A8, 1'b0, 1'b0, 1'b1, 15, "after_abort");

        // Async reset mid-ITER and while driving the result.
        capture(0, 32'h4500, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0; #1;
        check("rst_iter/outs", {26'h0, bus_z, res[0], nan[0], pinf[0], ninf[0], inx[0]}, 32'h20);
        @(negedge clk); rst_n = 1'b1;
        capture(0, 32'h7BFF, 1'b0);
        wait_result(lat);
        check("rst_done/pre", {31'h0, res[0]}, 32'd1);
        #2 rst_n = 1'b0; #1;
        check("rst_done/outs", {26'h0, bus_z, res[0], nan[0], pinf[0], ninf[0], inx[0]}, 32'h20);
        @(negedge clk); rst_n = 1'b1;
        run(0, 32'h4500, 1'b0, 32'h4078, 1'b0, 1'b0, 1'b1, 15, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_sqrt_param.md
Name: fp_sqrt_param

Overview:
Parametrised IEEE-754 square-root unit, successor to the fixed FP16 sqrt2 block. It is generic in exponent and mantissa width, so one RTL covers FP16, BF16 and FP32. It adds a selectable rounding mode, an inexact flag, and a configurable number of root bits per cycle. It keeps the family's shared bidirectional data bus with ENABLE/RESULT handshake and sits on the same host bus as sqrt2.

Parameters:
EXP_W, 5, exponent field width (>=3)
MAN_W, 10, stored mantissa field width (>=2)
BPC, 1, root bits resolved per iteration cycle (1, 2 or 4)
W, EXP_W+MAN_W+1, derived total word width (localparam, not overridable)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  request/hold; low aborts and re-arms
RM  in  1  rounding mode, sampled at capture: 0=RTZ (sqrt2-compatible), 1=RNE
IO_DATA  inout  W  operand in (host drives), result out (block drives)
RESULT  out  1  result valid on IO_DATA
IS_NAN  out  1  result is NaN
IS_PINF  out  1  result is +inf
IS_NINF  out  1  result is -inf (never set by sqrt; port kept for bus compatibility)
IS_INEXACT  out  1  rounded result differs from exact root

Behaviour:
- Reset (async, RST_N=0): state IDLE; RESULT, all flags 0; IO_DATA Hi-Z; internal registers cleared. Reset mid-operation discards the operation.
- States: IDLE -> CLASSIFY -> NORM -> ITER -> PACK -> DONE. Special path: CLASSIFY -> PACK.
- IDLE: at the first posedge with ENABLE=1 and armed=1, capture IO_DATA and RM, clear armed, go to CLASSIFY. armed sets whenever ENABLE=0 at a posedge. A new request needs ENABLE low for at least one cycle.
- CLASSIFY: decode the operand.
  - NaN, -inf, or negative nonzero (incl. negative subnormal): canonical NaN {1, all-ones exponent, 1, zeros}, IS_NAN=1.
  - +inf: +inf, IS_PINF=1.
  - +0 / -0: same-signed zero, no flags.
  - All specials go to PACK.
  - Otherwise go to NORM.
- NORM (1 cycle): normalise subnormals with a leading-zero count, giving unbiased exponent e. If e is odd, shift the significand left 1 and decrement e. Result exponent = e/2 + bias, with arithmetic shift.
- ITER: restoring digit-by-digit root, BPC bits per cycle.
  - Computes MAN_W+2 root bits: the implicit 1, MAN_W fraction bits, and 1 guard bit.
  - Iteration count N = ceil((MAN_W+2)/BPC). Excess bits produced in the last cycle are discarded.
  - Remainder width is MAN_W+4 bits.
  - Sticky = (remainder != 0) OR (guard bit).
- PACK (1 cycle):
  - RTZ: truncate.
  - RNE: increment when guard=1 and (remainder!=0 or lsb=1). A mantissa carry-out increments the exponent. This cannot overflow, since sqrt never exceeds max finite.
  - IS_INEXACT = sticky (always 0 for specials).
  - Results are always normal for any input width >=3 exponent bits.
- DONE: RESULT=1; IO_DATA driven with the result and flags held while ENABLE=1.
  - Bus drive enable = (state==DONE) & ENABLE, combinational, so the bus is released in the same cycle ENABLE falls.
- ENABLE=0 in any non-IDLE state: go to IDLE on the next posedge; RESULT and flags clear at that edge.
- Latency from capture edge to RESULT=1: normal operand 3+N edges (FP16 with BPC=1: 15); special operand 2 edges.
- The block never drives IO_DATA before 2 edges after capture. The host must release the bus within 2 cycles of capture.

Decomposition:
- Package fp_sqrt_pkg:
  - state enum
  - RM encodings RM_RTZ/RM_RNE
  - function for canonical NaN built from EXP_W/MAN_W
  - classify result enum (ZERO, SUB, NORM, INF, NAN)
- One sub-module: fp_sqrt_step. Combinational BPC-bit restoring root step taking (remainder, partial root, next 2*BPC radicand bits) and returning the updated pair. It is instantiated once in the ITER datapath.

Test Plan:
- FP16, RM=0: 4400 -> 4000; 3800 -> 39A8 INEXACT=1; 0001 -> 0C00; 7BFF -> 5BFF; 4500 -> 4078. All with RESULT exactly 15 cycles after capture.
- FP16 RM=1 vs RM=0: 4200 -> 3EEE (RNE) / 3EED (RTZ), INEXACT=1; 4400 -> 4000 INEXACT=0 in both modes.
- Specials FP16: 7C00 -> 7C00 PINF; FC00/BC00/7E00/8001 -> FE00 NAN; 8000 -> 8000; 0000 -> 0000. RESULT 2 edges after capture.
- Width/BPC: BF16 (8,7) 4080 -> 4000; FP32 (8,23) BPC=4: 40800000 -> 40000000, 40000000 -> 3FB504F3 (RTZ) / 3FB504F3 (RNE).
- Abort/re-arm: drop ENABLE mid-ITER -> IO_DATA Hi-Z same cycle, IDLE next edge. Holding ENABLE high after DONE does not restart. Low-then-high starts a new capture.
- Async reset: assert RST_N low mid-ITER between clock edges -> RESULT/flags 0 and bus Hi-Z immediately; the next request after release computes correctly.
